pkt_prio_sched: RTL and testbench
=================================

// Module: pkt_prio_sched
// PURPOSE
//  Strict-priority output scheduler that sits directly downstream of pkt_Priorer and consumes its
//  (out_valid, out_data, out_prior) stream. It maps each 6-bit priority onto one of NUM_CLASS
//  classes and buffers each class in its own circular FIFO. It always presents the head entry of
//  the highest non-empty class to the egress consumer.
// PARAMETERS
//  DWIDTH       32  payload width, equal to pkt_Priorer DWIDTH
//  PRIO_W        6  priority width
//  NUM_CLASS     4  number of classes; power of 2, range 2..8
//  CLASS_DEPTH   8  entries per class FIFO; power of 2
//  CNT_W        16  statistics counter width
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   reset, asynchronous, active-high
//  in_en         in   1                   ingress write strobe (from pkt_Priorer out_valid)
//  in_valid      out  1                   ingress ready: target class of in_prior is not full (comb)
//  in_data       in   DWIDTH              ingress payload
//  in_prior      in   PRIO_W              ingress priority
//  in_drop       out  1                   1-cycle pulse: in_en while !in_valid; entry discarded
//  out_deque_en  in   1                   egress pop request
//  out_valid     out  1                   some class is non-empty
//  out_data      out  DWIDTH              head payload of the selected class
//  out_prior     out  PRIO_W              head priority of the selected class
//  out_class     out  $clog2(NUM_CLASS)   selected class index
//  class_empty   out  NUM_CLASS           per-class empty flags
//  stat_drop_cnt out  NUM_CLASS*CNT_W     per-class drop counters; class c in bits [c*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high.
//  - Class mapping: class = in_prior[PRIO_W-1 -: $clog2(NUM_CLASS)]. A higher class is served first.
//  - Push: in_en && in_valid writes {in_data, in_prior} at the wptr of the target class.
//    - The class wptr and count update at the clock edge.
//    - The entry becomes visible on the out_* ports in the next cycle (1-cycle write-to-out latency).
//  - Full: in_valid is derived from the registered count only.
//    - A full class rejects a write even when the same class pops in the same cycle.
//    - A rejected write raises in_drop for exactly that cycle. Nothing else changes.
//  - Select: combinational priority encoder over ~class_empty, highest index wins.
//    - out_data, out_prior and out_class come from the head (rptr) of the selected class.
//  - Pop: out_deque_en && out_valid advances rptr and decrements count of the selected class.
//    - out_deque_en while !out_valid is ignored. No underflow occurs.
//  - Simultaneous push and pop on the same non-full class: both take effect and count is unchanged.
//  - Pop of one class with push to another class: independent.
//  - Wrap-around: pointers are $clog2(CLASS_DEPTH) bits and wrap naturally.
//    - count is $clog2(CLASS_DEPTH)+1 bits. full = (count == CLASS_DEPTH).
//  - No reordering: FIFO order is preserved within a class. Across classes the order is strict
//    priority, which can starve lower classes by design.
//  - Reset values: all pointers and counts = 0, class_empty = all 1s, out_valid = 0, in_drop = 0,
//    stat_drop_cnt = 0. Storage is not reset.
//  - Reset in mid-operation clears every queue immediately. Any buffered entries are lost.
//  - out_data, out_prior and out_class are don't-care while out_valid = 0. They are driven to 0.
// CONFIGURATION
//  PRIO_SCHED_STATS_EN
//  - Defined: each class has a saturating CNT_W-bit drop counter.
//    - The counter increments on every in_drop for that class and holds at all 1s.
//  - Undefined: stat_drop_cnt is tied to 0 and no counter flops are built.
//    - The port list is identical in both builds.
// STRUCTURE
//  - Shared package pkt_h gains:
//    - typedef struct packed {logic [DWIDTH-1:0] data; logic [5:0] prior;} prioEntry
//    - function prio2class()
//    - localparam PRIO_W = 6
//  - Sub-module prio_class_fifo holds storage, rptr, wptr, count and the full/empty flags.
//    - It takes wr_en, rd_en and din, and gives dout, full and empty.
//    - pkt_prio_sched generates NUM_CLASS instances of it.
//  - The top level holds the class decode, priority encoder, drop logic and stats counters.
// TESTING
//  Defaults throughout (NUM_CLASS=4, CLASS_DEPTH=8).
//  1. Reset, then idle.
//     -> out_valid=0, class_empty=4'b1111, in_valid=1, stat_drop_cnt=0.
//  2. Push prior 6'd5 (class 0) then 6'd50 (class 3) on consecutive cycles, no pop.
//     -> After 2 cycles out_class=3, out_prior=50.
//     -> After one pop, out_class=0, out_prior=5.
//  3. Push 8 entries of prior 6'd20 (class 1) with data 0..7, then a 9th with data 8.
//     -> in_valid=0 and in_drop=1 on the 9th.
//     -> Popping 8 times returns data 0..7 in order, then out_valid=0.
//  4. With class 2 holding 3 entries, push and pop class 2 in the same cycle for 20 cycles.
//     -> Count stays 3, pointers wrap, and data order is preserved.
//  5. Fill class 1, then hold in_en with prior 6'd20 for 70000 cycles.
//     -> Built with PRIO_SCHED_STATS_EN: stat_drop_cnt class 1 saturates at 16'hFFFF.
//     -> Built without it: the counter reads 0.
//  6. Assert rst asynchronously mid-burst with 3 classes non-empty.
//     -> out_valid drops to 0 before the next clk edge, and all class_empty bits are 1.

Source files
------------

// File: rtl/pkt_h.sv
// Shared packet types and helpers for the priority scheduler.
// Used by pkt_prio_sched (optional stats build: PRIO_SCHED_STATS_EN).
package pkt_h;

  localparam int PRIO_W = 6;
  localparam int DWIDTH = 32;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [5:0]        prior;
  } prioEntry;

  // Top cls_w bits of the priority select the class.
  function automatic logic [2:0] prio2class(
    input logic [5:0]  prior,
    input int unsigned cls_w
  );
    return 3'(prior >> (6 - cls_w));
  endfunction

endpackage

// File: rtl/prio_class_fifo.sv
// Circular FIFO holding one priority class of the scheduler.
// Writes when full and reads when empty are ignored.
module prio_class_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage is left unreset on purpose.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      if (do_wr && !do_rd)
        count <= count + 1'b1;
      else if (do_rd && !do_wr)
        count <= count - 1'b1;
    end
  end

  assign dout  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/pkt_prio_sched.sv
// Strict-priority egress scheduler with one FIFO per class.
// Define PRIO_SCHED_STATS_EN to build saturating per-class drop counters.
module pkt_prio_sched #(
  parameter int DWIDTH      = 32,
  parameter int PRIO_W      = 6,
  parameter int NUM_CLASS   = 4,
  parameter int CLASS_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_en,
  output logic                           in_valid,
  input  logic [DWIDTH-1:0]              in_data,
  input  logic [PRIO_W-1:0]              in_prior,
  output logic                           in_drop,
  input  logic                           out_deque_en,
  output logic                           out_valid,
  output logic [DWIDTH-1:0]              out_data,
  output logic [PRIO_W-1:0]              out_prior,
  output logic [$clog2(NUM_CLASS)-1:0]   out_class,
  output logic [NUM_CLASS-1:0]           class_empty,
  output logic [NUM_CLASS*CNT_W-1:0]     stat_drop_cnt
);

  import pkt_h::*;

  localparam int CW = $clog2(NUM_CLASS);
  localparam int EW = DWIDTH + PRIO_W;

  logic [CW-1:0]        cls;
  logic [CW-1:0]        sel;
  logic [NUM_CLASS-1:0] wr_en;
  logic [NUM_CLASS-1:0] rd_en;
  logic [NUM_CLASS-1:0] full;
  logic [NUM_CLASS-1:0] empty;
  logic [EW-1:0]        dout [NUM_CLASS];

  assign cls      = CW'(prio2class(6'(in_prior), CW));
  assign in_valid = !full[cls];
  assign in_drop  = in_en && !in_valid;

  // Highest non-empty class wins.
  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CLASS; c++)
      if (!empty[c]) sel = CW'(c);
  end

  assign out_valid = ~&empty;

  always_comb begin
    wr_en = '0;
    rd_en = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      wr_en[c] = in_en && in_valid && (cls == CW'(c));
      rd_en[c] = out_deque_en && out_valid && (sel == CW'(c));
    end
  end

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_cls
    prio_class_fifo #(
      .W     (EW),
      .DEPTH (CLASS_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en[g]),
      .rd_en (rd_en[g]),
      .din   ({in_data, in_prior}),
      .dout  (dout[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign {out_data, out_prior} = out_valid ? dout[sel] : '0;
  assign out_class   = sel;
  assign class_empty = empty;

`ifdef PRIO_SCHED_STATS_EN
  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_stat
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        cnt <= '0;
      else if (in_drop && cls == CW'(g) && cnt != '1)
        cnt <= cnt + 1'b1;
    end
    assign stat_drop_cnt[g*CNT_W +: CNT_W] = cnt;
  end
`else
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_prio_sched.sv
// Scoreboard bench for pkt_prio_sched against per-class queue model.
// Expected drop counters follow PRIO_SCHED_STATS_EN.
module tb_pkt_prio_sched;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_en = 0;
  logic        in_valid;
  logic [31:0] in_data = 0;
  logic [5:0]  in_prior = 0;
  logic        in_drop;
  logic        out_deque_en = 0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_prior;
  logic [1:0]  out_class;
  logic [3:0]  class_empty;
  logic [63:0] stat_drop_cnt;

  pkt_prio_sched dut (
    .clk           (clk),
    .rst           (rst),
    .in_en         (in_en),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_prior      (in_prior),
    .in_drop       (in_drop),
    .out_deque_en  (out_deque_en),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_prior     (out_prior),
    .out_class     (out_class),
    .class_empty   (class_empty),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  logic [37:0] mq [4][$];
  int          dc [4];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input logic [31:0] d,
                       input logic [5:0] p, input bit dq);
    @(posedge clk);
    #1;
    in_en        = en;
    in_data      = d;
    in_prior     = p;
    out_deque_en = dq;
  endtask

  // Monitor: compare DUT against model, then advance model like the edge will.
  always @(negedge clk) begin : mon
    int          sel;
    int          c;
    bit          any;
    bit          inv;
    logic [3:0]  ce;
    logic [63:0] st;
    if (!rst) begin
      any = 0;
      sel = 0;
      ce  = '1;
      for (int i = 0; i < 4; i++)
        if (mq[i].size() > 0) begin
          any   = 1;
          sel   = i;
          ce[i] = 0;
        end
      chk("out_valid", out_valid, any);
      chk("class_empty", class_empty, ce);
      c   = int'(in_prior[5:4]);
      inv = mq[c].size() < 8;
      chk("in_valid", in_valid, inv);
      chk("in_drop", in_drop, in_en && !inv);
      if (any) begin
        chk("out_class", out_class, sel);
        chk("out_entry", {out_data, out_prior}, mq[sel][0]);
      end else begin
        chk("out_idle", {out_class, out_data, out_prior}, 0);
      end
      st = 0;
`ifdef PRIO_SCHED_STATS_EN
      for (int i = 0; i < 4; i++) st[i*16 +: 16] = 16'(dc[i]);
`endif
      chk("stat_drop_cnt", stat_drop_cnt, st);
      if (out_deque_en && any) void'(mq[sel].pop_front());
      if (in_en) begin
        if (inv) mq[c].push_back({in_data, in_prior});
        else if (dc[c] < 65535) dc[c]++;
      end
    end
  end

  initial begin
    int pct;
    for (int i = 0; i < 4; i++) dc[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset and idle
    @(negedge clk);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_class_empty", class_empty, 4'hF);
    chk("t1_in_valid", in_valid, 1);
    chk("t1_stat", stat_drop_cnt, 0);

    // Class 0 then class 3; class 3 served first
    drive(1, 32'hA0, 6'd5, 0);
    drive(1, 32'hB3, 6'd50, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_class_hi", out_class, 3);
    chk("t2_prior_hi", out_prior, 50);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_class_lo", out_class, 0);
    chk("t2_prior_lo", out_prior, 5);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    // Fill class 1, overflow, drain in order
    for (int i = 0; i < 8; i++) drive(1, i, 6'd20, 0);
    drive(1, 8, 6'd20, 0);
    @(negedge clk);
    chk("t3_in_valid", in_valid, 0);
    chk("t3_in_drop", in_drop, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 6'd20, 1);
      @(negedge clk);
      chk("t3_pop_data", out_data, i);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("t3_drained", out_valid, 0);

    // Steady push+pop on class 2 with 3 entries resident
    for (int i = 0; i < 3; i++) drive(1, 100 + i, 6'd40, 0);
    for (int i = 0; i < 20; i++) drive(1, 200 + i, 6'd40, 1);
    @(negedge clk);
    chk("t4_head", out_data, 216);
    chk("t4_not_full", in_valid, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    // Saturate class 1 drop counter
    for (int i = 0; i < 8; i++) drive(1, 300 + i, 6'd20, 0);
    for (int i = 0; i < 70000; i++) drive(1, 999, 6'd20, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
`ifdef PRIO_SCHED_STATS_EN
    chk("t5_sat", stat_drop_cnt[31:16], 16'hFFFF);
`else
    chk("t5_sat", stat_drop_cnt[31:16], 0);
`endif
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);

    // Asynchronous reset mid-burst
    drive(1, 1, 6'd5, 0);
    drive(1, 2, 6'd20, 0);
    drive(1, 3, 6'd50, 0);
    drive(1, 4, 6'd50, 0);
    @(posedge clk);
    #3;
    rst          = 1;
    in_en        = 0;
    out_deque_en = 0;
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      dc[i] = 0;
    end
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_class_empty", class_empty, 4'hF);
    chk("t6_stat", stat_drop_cnt, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;

    // Randomized traffic with varying drain pressure
    for (int b = 0; b < 6; b++) begin
      pct = 20 + 10 * b;
      for (int i = 0; i < 500; i++)
        drive($urandom_range(0, 3) != 0, $urandom,
              6'($urandom_range(0, 63)),
              $urandom_range(0, 99) < pct);
    end
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("final_empty", class_empty, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
